dport_axil_bridge: RTL and testbench
====================================

DPORT_AXIL_BRIDGE -- requirements
Module: dport_axil_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256: cycles the bus may stall before the bridge forces an error response (used only when the timeout feature is compiled in).
REQ-002 SHALL have ports, clock and reset first:
- clk_i  in  1  sole clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- mem_d_addr_i  in  32  request byte address
- mem_d_data_wr_i  in  32  write data
- mem_d_rd_i  in  1  read request
- mem_d_wr_i  in  4  byte write strobes
- mem_d_cacheable_i  in  1  ignored
- mem_d_req_tag_i  in  11  request tag
- mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i  in  1 each  cache-maintenance ops (CMO)
- mem_d_data_rd_o  out  32  read data
- mem_d_accept_o  out  1  request accepted this cycle
- mem_d_ack_o  out  1  response valid, one-cycle pulse
- mem_d_error_o  out  1  response is an error, qualified by ack
- mem_d_resp_tag_o  out  11  tag of the responding request
- axi_awvalid_o / axi_awready_i / axi_awaddr_o[31:0]: AXI4-Lite write address
- axi_wvalid_o / axi_wready_i / axi_wdata_o[31:0] / axi_wstrb_o[3:0]: write data
- axi_bvalid_i / axi_bready_o / axi_bresp_i[1:0]: write response
- axi_arvalid_o / axi_arready_i / axi_araddr_o[31:0]: read address
- axi_rvalid_i / axi_rready_o / axi_rdata_i[31:0] / axi_rresp_i[1:0]: read data
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 The block SHALL be the responder on the core data port, with at most one request outstanding.
REQ-005 mem_d_accept_o SHALL be 1 only in IDLE; a request is taken when accept=1 and any of rd, |wr, or a CMO is asserted.
REQ-006 FSM states SHALL be IDLE, WADDR, WRESP, RADDR, RDATA and RESP. Transitions:
- IDLE→WADDR on write.
- IDLE→RADDR on read.
- IDLE→RESP on CMO.
REQ-007 Priority on simultaneous inputs SHALL be write > read > CMO; lower-priority inputs are dropped.
REQ-008 On accept, the block SHALL register the tag, the word-aligned address {addr[31:2],2'b00}, the write data and the strobes.
REQ-009 WADDR SHALL assert awvalid and wvalid together.
- Each SHALL drop independently after its own handshake.
- The FSM moves to WRESP only when both handshakes have completed; same-cycle or different-cycle completion SHALL both work.
REQ-010 WRESP SHALL hold bready=1; on bvalid, capture bresp and go to RESP.
REQ-011 RADDR SHALL hold arvalid until arready, then go to RDATA.
REQ-012 RDATA SHALL hold rready=1; on rvalid, capture rdata and rresp, then go to RESP.
REQ-013 RESP SHALL pulse mem_d_ack_o for exactly one cycle with the captured tag, then return to IDLE.
- mem_d_error_o = (captured resp != 2'b00).
- data_rd = captured rdata for reads, 0 for writes and CMOs.
REQ-014 Latency: the ack SHALL be asserted the cycle after the B/R handshake; a CMO ack SHALL come 1 cycle after accept; accept SHALL return the cycle after the ack.
REQ-015 AXI valids SHALL never deassert before their ready is seen, and the AXI address and data outputs SHALL be stable while valid=1.

Reset
REQ-016 With rst_i=1 at a clock edge:
- State SHALL go to IDLE.
- All AXI valid and ready outputs, mem_d_ack_o, mem_d_error_o, mem_d_data_rd_o and mem_d_resp_tag_o SHALL become 0.
- mem_d_accept_o SHALL read 1 from the first cycle after reset.
REQ-017 Reset mid-transaction SHALL abandon the transaction without issuing an ack; the downstream AXI slave is reset together with the bridge.

Configuration
REQ-018 With DPORT_AXIL_TIMEOUT_EN defined:
- A counter SHALL clear on each state entry and increment in WADDR, WRESP, RADDR and RDATA.
- On reaching TIMEOUT_CYCLES, the FSM SHALL go to RESP with error=1 and data 0, and drop all AXI valids and readies.
REQ-019 Without DPORT_AXIL_TIMEOUT_EN, the block SHALL have no counter and SHALL wait indefinitely.

Structure
REQ-020 A shared package SHALL hold the FSM state encoding and the AXI response constants (OKAY=2'b00, SLVERR=2'b10).
REQ-021 The block SHALL be a single module with no sub-modules.

Verification
REQ-022 Read: rd=1, addr=0x8000_0106, tag=0x155, arready=1, rvalid 3 cycles later with rdata=0xDEADBEEF and OKAY → araddr=0x8000_0104, then ack=1, data=0xDEADBEEF, tag=0x155, error=0.
REQ-023 Write: wr=4'b0011, data=0x1234_5678, wready 2 cycles before awready, then bresp=SLVERR → wstrb=0011 held stable, one ack with error=1 and data_rd=0.
REQ-024 Simultaneous rd=1, wr=4'hF and flush=1 → only the AW/W channels are driven; exactly one ack.
REQ-025 CMO: flush=1, tag=0x7FF → ack exactly 1 cycle after accept, no AXI valid asserted, tag=0x7FF.
REQ-026 Timeout: with DPORT_AXIL_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, arready held 0 → ack with error=1 after 16 cycles and arvalid dropped.
REQ-027 Reset during RDATA → next cycle accept=1 and ack=0, and no stale ack ever appears.

Source files
------------

// File: rtl/dport_axil_bridge_pkg.sv
// Shared definitions for the core data-port to AXI4-Lite bridge: FSM state
// encoding, AXI response codes, request record and address helper.
package dport_axil_bridge_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WADDR = 3'd1;
  localparam logic [2:0] ST_WRESP = 3'd2;
  localparam logic [2:0] ST_RADDR = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_WRITE,
    REQ_READ,
    REQ_CMO
  } req_kind_e;

  typedef struct packed {
    logic [10:0] tag;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } req_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dport_axil_bridge.sv
// Single-outstanding bridge from the core data port onto AXI4-Lite.
// Define DPORT_AXIL_TIMEOUT_EN to compile in the bus-stall timeout.
module dport_axil_bridge
  import dport_axil_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] mem_d_addr_i,
  input  logic [31:0] mem_d_data_wr_i,
  input  logic        mem_d_rd_i,
  input  logic [3:0]  mem_d_wr_i,
  input  logic        mem_d_cacheable_i,
  input  logic [10:0] mem_d_req_tag_i,
  input  logic        mem_d_invalidate_i,
  input  logic        mem_d_writeback_i,
  input  logic        mem_d_flush_i,
  output logic [31:0] mem_d_data_rd_o,
  output logic        mem_d_accept_o,
  output logic        mem_d_ack_o,
  output logic        mem_d_error_o,
  output logic [10:0] mem_d_resp_tag_o,
  output logic        axi_awvalid_o,
  input  logic        axi_awready_i,
  output logic [31:0] axi_awaddr_o,
  output logic        axi_wvalid_o,
  input  logic        axi_wready_i,
  output logic [31:0] axi_wdata_o,
  output logic [3:0]  axi_wstrb_o,
  input  logic        axi_bvalid_i,
  output logic        axi_bready_o,
  input  logic [1:0]  axi_bresp_i,
  output logic        axi_arvalid_o,
  input  logic        axi_arready_i,
  output logic [31:0] axi_araddr_o,
  input  logic        axi_rvalid_i,
  output logic        axi_rready_o,
  input  logic [31:0] axi_rdata_i,
  input  logic [1:0]  axi_rresp_i
);

  logic [2:0]  state_q, state_d;
  req_t        req_q, req_d;
  logic        aw_pend_q, aw_pend_d;
  logic        w_pend_q, w_pend_d;
  logic [1:0]  resp_q, resp_d;
  logic [31:0] rdata_q, rdata_d;
  req_kind_e   kind;
  logic        tmo_hit;

  // Cacheability and byte offset carry no meaning for a word-wide AXI-Lite access.
  logic unused_inputs;
  assign unused_inputs = ^{mem_d_cacheable_i, mem_d_addr_i[1:0], 32'(TIMEOUT_CYCLES)};

  always_comb begin
    kind = REQ_NONE;
    if (|mem_d_wr_i) begin
      kind = REQ_WRITE;
    end else if (mem_d_rd_i) begin
      kind = REQ_READ;
    end else if (mem_d_invalidate_i || mem_d_writeback_i || mem_d_flush_i) begin
      kind = REQ_CMO;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (kind != REQ_NONE) begin
          req_d.tag   = mem_d_req_tag_i;
          req_d.addr  = word_align(mem_d_addr_i);
          req_d.wdata = mem_d_data_wr_i;
          req_d.strb  = mem_d_wr_i;
          resp_d      = AXI_RESP_OKAY;
          rdata_d     = '0;
          case (kind)
            REQ_WRITE: begin
              state_d   = ST_WADDR;
              aw_pend_d = 1'b1;
              w_pend_d  = 1'b1;
            end
            REQ_READ: state_d = ST_RADDR;
            default:  state_d = ST_RESP;
          endcase
        end
      end
      ST_WADDR: begin
        // AW and W retire independently; the phase ends once both have.
        aw_pend_d = aw_pend_q & ~axi_awready_i;
        w_pend_d  = w_pend_q & ~axi_wready_i;
        if (!aw_pend_d && !w_pend_d) begin
          state_d = ST_WRESP;
        end else if (tmo_hit) begin
          state_d = ST_RESP;
          resp_d  = AXI_RESP_SLVERR;
        end
      end
      ST_WRESP: begin
        if (axi_bvalid_i) begin
          resp_d  = axi_bresp_i;
          state_d = ST_RESP;
        end else if (tmo_hit) begin
          state_d = ST_RESP;
          resp_d  = AXI_RESP_SLVERR;
        end
      end
      ST_RADDR: begin
        if (axi_arready_i) begin
          state_d = ST_RDATA;
        end else if (tmo_hit) begin
          state_d = ST_RESP;
          resp_d  = AXI_RESP_SLVERR;
        end
      end
      ST_RDATA: begin
        if (axi_rvalid_i) begin
          rdata_d = axi_rdata_i;
          resp_d  = axi_rresp_i;
          state_d = ST_RESP;
        end else if (tmo_hit) begin
          state_d = ST_RESP;
          resp_d  = AXI_RESP_SLVERR;
          rdata_d = '0;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef DPORT_AXIL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counts cycles spent in the current bus-wait state; restarts on every state change.
  assign tmo_hit = (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_d != state_q) begin
      tmo_cnt_d = '0;
    end else if (state_q == ST_WADDR || state_q == ST_WRESP ||
                 state_q == ST_RADDR || state_q == ST_RDATA) begin
      tmo_cnt_d = tmo_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      resp_q    <= AXI_RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign mem_d_accept_o   = (state_q == ST_IDLE);
  assign mem_d_ack_o      = (state_q == ST_RESP);
  assign mem_d_error_o    = mem_d_ack_o && (resp_q != AXI_RESP_OKAY);
  assign mem_d_data_rd_o  = mem_d_ack_o ? rdata_q : '0;
  assign mem_d_resp_tag_o = req_q.tag;

  assign axi_awvalid_o = (state_q == ST_WADDR) && aw_pend_q;
  assign axi_wvalid_o  = (state_q == ST_WADDR) && w_pend_q;
  assign axi_awaddr_o  = req_q.addr;
  assign axi_wdata_o   = req_q.wdata;
  assign axi_wstrb_o   = req_q.strb;
  assign axi_bready_o  = (state_q == ST_WRESP);
  assign axi_arvalid_o = (state_q == ST_RADDR);
  assign axi_araddr_o  = req_q.addr;
  assign axi_rready_o  = (state_q == ST_RDATA);

endmodule

// File: tb/tb_dport_axil_bridge.sv
// Bench for dport_axil_bridge: directed scenarios plus randomized traffic against
// a channel-phase reference model; timeout cases run when DPORT_AXIL_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_dport_axil_bridge;

  localparam int TMO = 16;
  localparam int PH_NONE = 0, PH_AW = 1, PH_B = 2, PH_AR = 3, PH_R = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] mem_d_addr_i = '0, mem_d_data_wr_i = '0;
  logic        mem_d_rd_i = 1'b0, mem_d_cacheable_i = 1'b0;
  logic [3:0]  mem_d_wr_i = '0;
  logic [10:0] mem_d_req_tag_i = '0;
  logic        mem_d_invalidate_i = 1'b0, mem_d_writeback_i = 1'b0, mem_d_flush_i = 1'b0;
  logic [31:0] mem_d_data_rd_o;
  logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
  logic [10:0] mem_d_resp_tag_o;
  logic        axi_awvalid_o, axi_awready_i = 1'b0;
  logic [31:0] axi_awaddr_o;
  logic        axi_wvalid_o, axi_wready_i = 1'b0;
  logic [31:0] axi_wdata_o;
  logic [3:0]  axi_wstrb_o;
  logic        axi_bvalid_i = 1'b0, axi_bready_o;
  logic [1:0]  axi_bresp_i = '0;
  logic        axi_arvalid_o, axi_arready_i = 1'b0;
  logic [31:0] axi_araddr_o;
  logic        axi_rvalid_i = 1'b0, axi_rready_o;
  logic [31:0] axi_rdata_i = '0;
  logic [1:0]  axi_rresp_i = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  dport_axil_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i),
    .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i),
    .mem_d_cacheable_i(mem_d_cacheable_i), .mem_d_req_tag_i(mem_d_req_tag_i),
    .mem_d_invalidate_i(mem_d_invalidate_i), .mem_d_writeback_i(mem_d_writeback_i),
    .mem_d_flush_i(mem_d_flush_i),
    .mem_d_data_rd_o(mem_d_data_rd_o), .mem_d_accept_o(mem_d_accept_o),
    .mem_d_ack_o(mem_d_ack_o), .mem_d_error_o(mem_d_error_o),
    .mem_d_resp_tag_o(mem_d_resp_tag_o),
    .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i), .axi_awaddr_o(axi_awaddr_o),
    .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
    .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o),
    .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o), .axi_bresp_i(axi_bresp_i),
    .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i), .axi_araddr_o(axi_araddr_o),
    .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o),
    .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: one outstanding request, channel phases ----------------
  int          m_ph = PH_NONE;
  bit          m_busy = 1'b0, m_ack = 1'b0, m_aw_done, m_w_done, m_err, m_done;
  int          m_cnt;
  logic [10:0] m_tag;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_strb;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      chk("accept", mem_d_accept_o, !m_busy);
      chk("ack", mem_d_ack_o, m_ack);
      if (m_ack) begin
        chk("resp_tag", mem_d_resp_tag_o, m_tag);
        chk("error", mem_d_error_o, m_err);
        chk("data_rd", mem_d_data_rd_o, m_rdata);
      end
      chk("awvalid", axi_awvalid_o, (m_ph == PH_AW) && !m_aw_done);
      chk("wvalid", axi_wvalid_o, (m_ph == PH_AW) && !m_w_done);
      chk("bready", axi_bready_o, m_ph == PH_B);
      chk("arvalid", axi_arvalid_o, m_ph == PH_AR);
      chk("rready", axi_rready_o, m_ph == PH_R);
      if (m_ph == PH_AW && !m_aw_done) chk("awaddr", axi_awaddr_o, m_addr);
      if (m_ph == PH_AW && !m_w_done) begin
        chk("wdata", axi_wdata_o, m_wdata);
        chk("wstrb", axi_wstrb_o, m_strb);
      end
      if (m_ph == PH_AR) chk("araddr", axi_araddr_o, m_addr);
    end
    if (rst_i) begin
      m_busy = 1'b0; m_ack = 1'b0; m_ph = PH_NONE;
    end else if (m_ack) begin
      m_ack = 1'b0; m_busy = 1'b0;
    end else if (!m_busy) begin
      if (mem_d_rd_i || (|mem_d_wr_i) || mem_d_invalidate_i || mem_d_writeback_i || mem_d_flush_i) begin
        m_busy = 1'b1; m_tag = mem_d_req_tag_i;
        m_addr = mem_d_addr_i & 32'hFFFF_FFFC;
        m_wdata = mem_d_data_wr_i; m_strb = mem_d_wr_i;
        m_rdata = '0; m_err = 1'b0; m_cnt = 0; m_aw_done = 1'b0; m_w_done = 1'b0;
        if (|mem_d_wr_i)     m_ph = PH_AW;
        else if (mem_d_rd_i) m_ph = PH_AR;
        else begin m_ph = PH_NONE; m_ack = 1'b1; end
      end
    end else begin
      m_done = 1'b0;
      case (m_ph)
        PH_AW: begin
          if (axi_awready_i) m_aw_done = 1'b1;
          if (axi_wready_i)  m_w_done = 1'b1;
          if (m_aw_done && m_w_done) begin m_ph = PH_B; m_done = 1'b1; end
        end
        PH_B: if (axi_bvalid_i) begin
          m_ph = PH_NONE; m_ack = 1'b1; m_err = (axi_bresp_i != 2'b00); m_done = 1'b1;
        end
        PH_AR: if (axi_arready_i) begin m_ph = PH_R; m_done = 1'b1; end
        PH_R: if (axi_rvalid_i) begin
          m_ph = PH_NONE; m_ack = 1'b1; m_rdata = axi_rdata_i;
          m_err = (axi_rresp_i != 2'b00); m_done = 1'b1;
        end
        default: ;
      endcase
      if (m_done) m_cnt = 0;
      else        m_cnt++;
`ifdef DPORT_AXIL_TIMEOUT_EN
      if (!m_done && m_cnt == TMO) begin
        m_ph = PH_NONE; m_ack = 1'b1; m_err = 1'b1; m_rdata = '0;
      end
`endif
    end
  end

  // ---------------- AXI slave with per-channel delays ----------------
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int          aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
  logic [1:0]  b_rsp = '0, r_rsp = '0;
  logic [31:0] r_dat = '0;

  task automatic step();
    @(posedge clk_i);
    #1;
    if (axi_awvalid_o) begin axi_awready_i = (aw_c >= aw_dly); aw_c++; end
    else begin axi_awready_i = 1'b0; aw_c = 0; end
    if (axi_wvalid_o) begin axi_wready_i = (w_c >= w_dly); w_c++; end
    else begin axi_wready_i = 1'b0; w_c = 0; end
    if (axi_bready_o) begin axi_bvalid_i = (b_c >= b_dly); axi_bresp_i = b_rsp; b_c++; end
    else begin axi_bvalid_i = 1'b0; axi_bresp_i = '0; b_c = 0; end
    if (axi_arvalid_o) begin axi_arready_i = (ar_c >= ar_dly); ar_c++; end
    else begin axi_arready_i = 1'b0; ar_c = 0; end
    if (axi_rready_o) begin
      axi_rvalid_i = (r_c >= r_dly); axi_rdata_i = r_dat; axi_rresp_i = r_rsp; r_c++;
    end else begin
      axi_rvalid_i = 1'b0; axi_rdata_i = '0; axi_rresp_i = '0; r_c = 0;
    end
  endtask

  task automatic clear_req();
    mem_d_rd_i = 1'b0; mem_d_wr_i = '0;
    mem_d_invalidate_i = 1'b0; mem_d_writeback_i = 1'b0; mem_d_flush_i = 1'b0;
  endtask

  task automatic drive_noise();
    mem_d_rd_i = 1'($urandom); mem_d_wr_i = 4'($urandom);
    mem_d_invalidate_i = 1'($urandom); mem_d_writeback_i = 1'($urandom); mem_d_flush_i = 1'($urandom);
    mem_d_addr_i = $urandom; mem_d_data_wr_i = $urandom; mem_d_req_tag_i = 11'($urandom);
  endtask

  task automatic issue(input bit r, input logic [3:0] w, input bit inv, input bit wb, input bit fl,
                       input logic [31:0] a, input logic [31:0] d, input logic [10:0] t);
    int k = 0;
    while (!mem_d_accept_o && k < 300) begin step(); k++; end
    chk("accept_wait_bound", mem_d_accept_o, 1'b1);
    mem_d_rd_i = r; mem_d_wr_i = w; mem_d_invalidate_i = inv; mem_d_writeback_i = wb;
    mem_d_flush_i = fl; mem_d_addr_i = a; mem_d_data_wr_i = d; mem_d_req_tag_i = t;
    mem_d_cacheable_i = 1'($urandom);
    step();
    clear_req();
  endtask

  // n = extra cycles after the take edge until ack is visible (0 means the very next cycle).
  task automatic wait_ack(input bit noise, output int n);
    n = 0;
    while (!mem_d_ack_o && n < 300) begin
      step(); n++;
      if (noise && !mem_d_accept_o && !mem_d_ack_o) drive_noise();
    end
    clear_req();
    chk("ack_wait_bound", mem_d_ack_o, 1'b1);
    if (!mem_d_ack_o) begin
      rst_i = 1'b1; step(); rst_i = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, kind;
    logic [3:0] w;
    bit r, inv, wb, fl;

    repeat (3) step();
    rst_i = 1'b0;
    chk("rst_accept", mem_d_accept_o, 1'b1);
    chk("rst_ack", mem_d_ack_o, 1'b0);
    chk("rst_error", mem_d_error_o, 1'b0);
    chk("rst_data", mem_d_data_rd_o, 32'h0);
    chk("rst_tag", mem_d_resp_tag_o, 11'h0);
    chk("rst_valids", {axi_awvalid_o, axi_wvalid_o, axi_arvalid_o, axi_bready_o, axi_rready_o}, 5'b0);
    $display("txn reset: accept=%0d ack=%0d", mem_d_accept_o, mem_d_ack_o);

    // Read with word alignment of the address and a 3-cycle R delay
    ar_dly = 0; r_dly = 3; r_rsp = 2'b00; r_dat = 32'hDEADBEEF;
    issue(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 32'h8000_0106, 32'h0, 11'h155);
    chk("rd_arvalid", axi_arvalid_o, 1'b1);
    chk("rd_araddr", axi_araddr_o, 32'h8000_0104);
    wait_ack(1'b0, n);
    chk("rd_latency", n, 5);
    chk("rd_data", mem_d_data_rd_o, 32'hDEADBEEF);
    chk("rd_tag", mem_d_resp_tag_o, 11'h155);
    chk("rd_error", mem_d_error_o, 1'b0);
    $display("txn read: data=%h tag=%h err=%0d", mem_d_data_rd_o, mem_d_resp_tag_o, mem_d_error_o);
    step();

    // Write: W completes two cycles before AW, slave answers SLVERR
    aw_dly = 2; w_dly = 0; b_dly = 1; b_rsp = 2'b10;
    issue(1'b0, 4'b0011, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h1234_5678, 11'h0A5);
    chk("wr_both_valid", {axi_awvalid_o, axi_wvalid_o}, 2'b11);
    chk("wr_strb", axi_wstrb_o, 4'b0011);
    step();
    chk("wr_w_dropped_first", {axi_awvalid_o, axi_wvalid_o}, 2'b10);
    wait_ack(1'b0, n);
    chk("wr_error", mem_d_error_o, 1'b1);
    chk("wr_data", mem_d_data_rd_o, 32'h0);
    chk("wr_tag", mem_d_resp_tag_o, 11'h0A5);
    $display("txn write: err=%0d data=%h", mem_d_error_o, mem_d_data_rd_o);
    step();

    // Simultaneous write, read and flush: write wins
    aw_dly = 0; w_dly = 1; b_dly = 0; b_rsp = 2'b00;
    issue(1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 11'h321);
    chk("pri_channels", {axi_awvalid_o, axi_wvalid_o, axi_arvalid_o}, 3'b110);
    wait_ack(1'b0, n);
    chk("pri_error", mem_d_error_o, 1'b0);
    step();
    chk("pri_single_ack", mem_d_ack_o, 1'b0);
    chk("pri_accept_back", mem_d_accept_o, 1'b1);
    $display("txn priority: single ack, ar untouched");

    // Cache maintenance: ack in the cycle right after the take
    issue(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 11'h7FF);
    chk("cmo_ack_now", mem_d_ack_o, 1'b1);
    chk("cmo_tag", mem_d_resp_tag_o, 11'h7FF);
    chk("cmo_no_axi", {axi_awvalid_o, axi_wvalid_o, axi_arvalid_o}, 3'b000);
    step();
    chk("cmo_accept_back", mem_d_accept_o, 1'b1);
    $display("txn cmo: tag=7ff");

    // Reset while waiting for read data
    ar_dly = 0; r_dly = 1000;
    issue(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 11'h0AA);
    for (int i = 0; i < 10 && !axi_rready_o; i++) step();
    chk("rst_mid_in_rdata", axi_rready_o, 1'b1);
    rst_i = 1'b1; step(); rst_i = 1'b0;
    chk("rst_mid_accept", mem_d_accept_o, 1'b1);
    chk("rst_mid_ack", mem_d_ack_o, 1'b0);
    chk("rst_mid_tag", mem_d_resp_tag_o, 11'h0);
    r_dly = 0;
    for (int i = 0; i < 8; i++) begin step(); chk("rst_mid_no_stale_ack", mem_d_ack_o, 1'b0); end
    $display("txn reset-in-rdata: no ack");

`ifdef DPORT_AXIL_TIMEOUT_EN
    ar_dly = 1000;
    issue(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0000_0080, 32'h0, 11'h066);
    wait_ack(1'b0, n);
    chk("tmo_latency", n, TMO);
    chk("tmo_error", mem_d_error_o, 1'b1);
    chk("tmo_data", mem_d_data_rd_o, 32'h0);
    chk("tmo_arvalid_dropped", axi_arvalid_o, 1'b0);
    $display("txn timeout: cycles=%0d err=%0d", n + 1, mem_d_error_o);
    step();
    ar_dly = 0;
`endif

    for (int t = 0; t < 300; t++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) begin r_dly = 20; aw_dly = 20; end
      b_rsp = 2'($urandom); r_rsp = 2'($urandom); r_dat = $urandom;
      kind = $urandom_range(0, 7);
      r = 1'b0; w = 4'h0; inv = 1'b0; wb = 1'b0; fl = 1'b0;
      if (kind < 3) begin
        w = 4'($urandom_range(1, 15)); r = 1'($urandom); fl = 1'($urandom);
      end else if (kind < 6) begin
        r = 1'b1; inv = 1'($urandom);
      end else begin
        inv = 1'($urandom); wb = 1'($urandom); fl = !(inv || wb) ? 1'b1 : 1'($urandom);
      end
      issue(r, w, inv, wb, fl, $urandom, $urandom, 11'($urandom));
      if ($urandom_range(0, 29) == 0) begin
        repeat ($urandom_range(0, 3)) step();
        rst_i = 1'b1; step(); rst_i = 1'b0;
        chk("rnd_rst_accept", mem_d_accept_o, 1'b1);
        chk("rnd_rst_ack", mem_d_ack_o, 1'b0);
        $display("txn %0d: reset mid-flight", t);
      end else begin
        wait_ack(1'b1, n);
        $display("txn %0d: kind=%0d tag=%h err=%0d data=%h cycles=%0d", t, kind,
                 mem_d_resp_tag_o, mem_d_error_o, mem_d_data_rd_o, n + 1);
      end
      repeat ($urandom_range(0, 2)) step();
    end

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
